inst_issue_ctrl: RTL and testbench
==================================

// Module: inst_issue_ctrl
// PURPOSE
// - Issue controller between fetch/decode and the scalar and vector pipelines.
// - Decodes each 26-bit instruction and routes it to the scalar or vector path.
//   The unselected path always receives NOP_INST.
// - Throttles vector issue to one per VEC_CYCLES cycles, because the vector unit
//   iterates over lanes.
// - Implements FENCE, downstream hold and front-end flush; counts stall cycles.
// PARAMETERS
// - VEC_CYCLES  4   cycles the vector unit is occupied per vector instruction (>=1)
// - CNT_W       16  width of saturating stall counter
// PORTS
// - clk          in   1      clock, rising edge
// - rst_n        in   1      asynchronous, active-low reset
// - flush        in   1      kill the instruction offered this cycle
// - hold         in   1      downstream stall; freeze issue outputs
// - inst_valid   in   1      inst holds a valid instruction
// - inst         in   26     instruction from fetch/decode
// - inst_ready   out  1      instruction accepted this cycle when inst_valid & inst_ready
// - inst_out     out  26     scalar pipeline instruction (registered)
// - inst_out_v   out  26     vector pipeline instruction (registered)
// - issue_s      out  1      inst_out carries a real scalar instruction
// - issue_v      out  1      inst_out_v carries a real vector instruction
// - vec_busy     out  1      vector occupancy counter nonzero
// - stall_cnt    out  CNT_W  saturating count of cycles where inst_valid & !inst_ready
// BEHAVIOUR
// - Decode on inst[25:22]:
//   - 4'hF is FENCE.
//   - Otherwise inst[25]=1 is VECTOR and inst[25]=0 is SCALAR.
// - Reset (async, rst_n=0) forces:
//   - inst_out = inst_out_v = NOP_INST (26'h0500000).
//   - issue_s = issue_v = 0, vcnt = 0, stall_cnt = 0, state = RUN.
// - inst_ready is combinational from flush, hold, vcnt, state and inst. It never depends on inst_valid.
//   - Forced to 0 when flush=1, hold=1 or state=FENCE_WAIT.
//   - SCALAR: ready = 1.
//   - VECTOR: ready = (vcnt==0).
//   - FENCE: ready = (vcnt==0).
// - Issue has one-cycle latency. An accept at edge N shows on the outputs after edge N:
//   - SCALAR: inst_out = inst, issue_s = 1; inst_out_v = NOP, issue_v = 0.
//   - VECTOR: inst_out_v = inst, issue_v = 1; inst_out = NOP; vcnt loads VEC_CYCLES-1.
//   - FENCE: both outputs NOP, both issue flags 0. FENCE is consumed and never forwarded.
// - No accept and hold=0: both outputs NOP, both issue flags 0 (bubble).
// - hold=1: all four issue outputs keep their values; nothing is accepted.
// - vcnt runs independently of hold and flush.
//   - Decrements every cycle while nonzero; saturates at 0.
//   - With VEC_CYCLES=1, vector ops can issue back-to-back.
//   - vec_busy = (vcnt!=0).
// - FSM:
//   - RUN -> FENCE_WAIT when a FENCE is valid and vcnt!=0.
//   - FENCE_WAIT -> RUN on the cycle vcnt reaches 0; the FENCE is accepted in that RUN cycle.
//   - flush in FENCE_WAIT returns to RUN.
// - flush has priority over everything except reset.
//   - The offered instruction is dropped and the outputs bubble next cycle (unless hold).
//   - An in-flight vector op is not cancelled; vcnt keeps counting.
// - Simultaneous flush and hold: hold wins for the outputs; nothing is accepted.
// - stall_cnt increments when inst_valid & !inst_ready & !flush. It saturates at all-ones.
// - Reset mid-operation discards any pending FENCE_WAIT and in-flight vcnt immediately.
// STRUCTURE
// - Shared package issue_pkg:
//   - NOP_INST = 26'h0500000, OPC_FENCE = 4'hF.
//   - typedef enum {RUN, FENCE_WAIT} issue_state_t.
//   - typedef enum {CLS_SCALAR, CLS_VECTOR, CLS_FENCE} inst_class_t.
// - Sub-module inst_class_dec: combinational 26-bit -> inst_class_t decoder, reused by hazard logic.
// - Remaining logic (FSM, vcnt, output registers, stall counter) stays in this module.
// TESTING
// 1. Reset: hold rst_n=0 mid-run with vcnt=2 -> outputs NOP, flags 0, vec_busy=0, stall_cnt=0 asynchronously.
// 2. Scalar stream:
//    - Stimulus: 26'h0012345, 26'h0054321 on consecutive cycles.
//    - Response: inst_out shows each one cycle later with issue_s=1; inst_out_v=NOP; inst_ready=1 throughout.
// 3. Vector throttle:
//    - Stimulus: VEC_CYCLES=4, vector ops 26'h2000001 and 26'h2000002 back-to-back.
//    - Response: the second is accepted 4 cycles after the first; inst_ready=0 for 3 cycles; stall_cnt=3.
// 4. Interleave:
//    - Stimulus: vector 26'h2000001 then scalar 26'h0000007.
//    - Response: the scalar issues on the next cycle while vec_busy=1.
// 5. FENCE:
//    - Stimulus: vector then FENCE 26'h3C00000.
//    - Response: FSM enters FENCE_WAIT; FENCE is accepted when vcnt hits 0; both paths NOP, flags 0.
// 6. Hold/flush:
//    - Stimulus: hold=1 while issue_s=1 with 26'h0000AAA.
//    - Response: the outputs stay frozen for the hold duration.
//    - Stimulus: flush with a valid scalar offered.
//    - Response: no issue next cycle; stall_cnt unchanged; vcnt still decrements.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and constants for the instruction issue controller.
package issue_pkg;

  localparam logic [25:0] NOP_INST  = 26'h0500000;
  localparam logic [3:0]  OPC_FENCE = 4'hF;

  typedef enum logic {
    RUN        = 1'b0,
    FENCE_WAIT = 1'b1
  } issue_state_t;

  typedef enum logic [1:0] {
    CLS_SCALAR = 2'd0,
    CLS_VECTOR = 2'd1,
    CLS_FENCE  = 2'd2
  } inst_class_t;

  // FENCE opcode takes precedence over the vector bit it shares.
  function automatic inst_class_t classify(logic [3:0] opc);
    if (opc == OPC_FENCE) begin
      return CLS_FENCE;
    end else if (opc[3]) begin
      return CLS_VECTOR;
    end else begin
      return CLS_SCALAR;
    end
  endfunction

endpackage

// File: rtl/inst_class_dec.sv
// Combinational instruction class decoder (scalar / vector / fence).
module inst_class_dec
  import issue_pkg::*;
(
  input  logic [25:0]  inst_i,
  output inst_class_t  cls_o
);

  // Only the opcode field selects the class.
  logic unused_operands;
  assign unused_operands = ^inst_i[21:0];

  // Decode opcode field into an instruction class.
  always_comb begin
    cls_o = classify(inst_i[25:22]);
  end

endmodule

// File: rtl/inst_issue_ctrl.sv
// Issue controller: routes decoded instructions to the scalar or vector
// pipeline, throttles vector issue, handles FENCE, hold, flush and counts stalls.
module inst_issue_ctrl
  import issue_pkg::*;
#(
  parameter int unsigned VEC_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             inst_valid,
  input  logic [25:0]      inst,
  output logic             inst_ready,
  output logic [25:0]      inst_out,
  output logic [25:0]      inst_out_v,
  output logic             issue_s,
  output logic             issue_v,
  output logic             vec_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned VcntW = (VEC_CYCLES > 1) ? $clog2(VEC_CYCLES) : 1;

  inst_class_t      cls;
  issue_state_t     state_q, state_d;
  logic [VcntW-1:0] vcnt_q, vcnt_d;
  logic [25:0]      out_s_q, out_s_d, out_v_q, out_v_d;
  logic             iss_s_q, iss_s_d, iss_v_q, iss_v_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             vcnt_zero;
  logic             vcnt_last;

  inst_class_dec u_dec (
    .inst_i (inst),
    .cls_o  (cls)
  );

  assign vcnt_zero = (vcnt_q == '0);
  // vcnt reaches zero at the coming edge.
  assign vcnt_last = vcnt_zero || (vcnt_q == VcntW'(1));

  // Ready decode; independent of inst_valid.
  always_comb begin
    inst_ready = 1'b0;
    if (!flush && !hold && (state_q == RUN)) begin
      unique case (cls)
        CLS_SCALAR: inst_ready = 1'b1;
        CLS_VECTOR: inst_ready = vcnt_zero;
        CLS_FENCE:  inst_ready = vcnt_zero;
        default:    inst_ready = 1'b0;
      endcase
    end
  end

  assign accept = inst_valid && inst_ready;

  // Next-state for issue registers, vector occupancy, FSM and stall counter.
  always_comb begin
    out_s_d = out_s_q;
    out_v_d = out_v_q;
    iss_s_d = iss_s_q;
    iss_v_d = iss_v_q;
    vcnt_d  = vcnt_zero ? vcnt_q : vcnt_q - VcntW'(1);
    state_d = state_q;
    stall_d = stall_q;

    if (!hold) begin
      out_s_d = NOP_INST;
      out_v_d = NOP_INST;
      iss_s_d = 1'b0;
      iss_v_d = 1'b0;
      if (accept) begin
        if (cls == CLS_SCALAR) begin
          out_s_d = inst;
          iss_s_d = 1'b1;
        end else if (cls == CLS_VECTOR) begin
          out_v_d = inst;
          iss_v_d = 1'b1;
        end
      end
    end

    // accept already implies vcnt was zero for a vector op.
    if (accept && (cls == CLS_VECTOR)) begin
      vcnt_d = VcntW'(VEC_CYCLES - 1);
    end

    if (state_q == RUN) begin
      if (!flush && inst_valid && (cls == CLS_FENCE) && !vcnt_zero) begin
        state_d = FENCE_WAIT;
      end
    end else begin
      // Leave early so the FENCE is accepted in the cycle vcnt is zero.
      if (flush || vcnt_last) begin
        state_d = RUN;
      end
    end

    if (inst_valid && !inst_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_s_q <= NOP_INST;
      out_v_q <= NOP_INST;
      iss_s_q <= 1'b0;
      iss_v_q <= 1'b0;
      vcnt_q  <= '0;
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      out_s_q <= out_s_d;
      out_v_q <= out_v_d;
      iss_s_q <= iss_s_d;
      iss_v_q <= iss_v_d;
      vcnt_q  <= vcnt_d;
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign inst_out   = out_s_q;
  assign inst_out_v = out_v_q;
  assign issue_s    = iss_s_q;
  assign issue_v    = iss_v_q;
  assign vec_busy   = !vcnt_zero;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Scoreboard bench for inst_issue_ctrl with directed, hand-computed vectors.
module tb_inst_issue_ctrl;

  localparam logic [25:0] NOP = 26'h0500000;
  localparam logic [25:0] FEN = 26'h3C00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        inst_valid = 1'b0;
  logic [25:0] inst = 26'h0;
  logic        inst_ready;
  logic [25:0] inst_out;
  logic [25:0] inst_out_v;
  logic        issue_s;
  logic        issue_v;
  logic        vec_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [25:0] o_s;
    logic [25:0] o_v;
    logic        s;
    logic        v;
    logic        busy;
    logic [15:0] stall;
    int          id;
  } exp_t;

  exp_t sb[$];

  inst_issue_ctrl #(
    .VEC_CYCLES (4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .hold       (hold),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_out_v (inst_out_v),
    .issue_s    (issue_s),
    .issue_v    (issue_v),
    .vec_busy   (vec_busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, id, got, exp);
    end
  endtask

  // Monitor: after every active edge compare outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst_out", e.id, 32'(inst_out), 32'(e.o_s));
      chk("inst_out_v", e.id, 32'(inst_out_v), 32'(e.o_v));
      chk("issue_s", e.id, 32'(issue_s), 32'(e.s));
      chk("issue_v", e.id, 32'(issue_v), 32'(e.v));
      chk("vec_busy", e.id, 32'(vec_busy), 32'(e.busy));
      chk("stall_cnt", e.id, 32'(stall_cnt), 32'(e.stall));
    end
  end

  int step_id = 0;

  // Drive one cycle, check ready before the edge, queue the post-edge expectation.
  task automatic step(input logic v, input logic [25:0] i, input logic fl, input logic hd,
                      input logic er, input logic [25:0] eo, input logic [25:0] eov,
                      input logic es, input logic ev, input logic eb, input int est);
    exp_t e;
    @(negedge clk);
    step_id++;
    inst_valid = v;
    inst = i;
    flush = fl;
    hold = hd;
    #1;
    chk("inst_ready", step_id, 32'(inst_ready), 32'(er));
    e.o_s = eo;
    e.o_v = eov;
    e.s = es;
    e.v = ev;
    e.busy = eb;
    e.stall = 16'(est);
    e.id = step_id;
    sb.push_back(e);
  endtask

  task automatic chk_reset_state(input int id);
    chk("rst_inst_out", id, 32'(inst_out), 32'(NOP));
    chk("rst_inst_out_v", id, 32'(inst_out_v), 32'(NOP));
    chk("rst_issue_s", id, 32'(issue_s), 32'd0);
    chk("rst_issue_v", id, 32'(issue_v), 32'd0);
    chk("rst_vec_busy", id, 32'(vec_busy), 32'd0);
    chk("rst_stall_cnt", id, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk_reset_state(0);
    @(negedge clk);
    rst_n = 1'b1;

    //   v     inst          fl    hd    rdy   inst_out      inst_out_v    s     v     busy  stall
    // Scalar stream
    step(1'b1, 26'h0012345, 1'b0, 1'b0, 1'b1, 26'h0012345, NOP,         1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 26'h0054321, 1'b0, 1'b0, 1'b1, 26'h0054321, NOP,         1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 0);
    // Vector throttle: second op waits 3 cycles
    step(1'b1, 26'h2000001, 1'b0, 1'b0, 1'b1, NOP,         26'h2000001, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 26'h2000002, 1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 1);
    step(1'b1, 26'h2000002, 1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 2);
    step(1'b1, 26'h2000002, 1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b0, 3);
    step(1'b1, 26'h2000002, 1'b0, 1'b0, 1'b1, NOP,         26'h2000002, 1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 3);
    // Interleave: scalar issues while vector unit busy
    step(1'b1, 26'h2000001, 1'b0, 1'b0, 1'b1, NOP,         26'h2000001, 1'b0, 1'b1, 1'b1, 3);
    step(1'b1, 26'h0000007, 1'b0, 1'b0, 1'b1, 26'h0000007, NOP,         1'b1, 1'b0, 1'b1, 3);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b1, 3);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 3);
    // FENCE behind a vector op: waits, then consumed with no issue
    step(1'b1, 26'h2000003, 1'b0, 1'b0, 1'b1, NOP,         26'h2000003, 1'b0, 1'b1, 1'b1, 3);
    step(1'b1, FEN,         1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 4);
    step(1'b1, FEN,         1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 5);
    step(1'b1, FEN,         1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b0, 6);
    step(1'b1, FEN,         1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 6);
    step(1'b1, 26'h0000AAA, 1'b0, 1'b0, 1'b1, 26'h0000AAA, NOP,         1'b1, 1'b0, 1'b0, 6);
    // Hold freezes outputs, counts stalls
    step(1'b1, 26'h0000BBB, 1'b0, 1'b1, 1'b0, 26'h0000AAA, NOP,         1'b1, 1'b0, 1'b0, 7);
    step(1'b1, 26'h0000BBB, 1'b0, 1'b1, 1'b0, 26'h0000AAA, NOP,         1'b1, 1'b0, 1'b0, 8);
    step(1'b1, 26'h0000BBB, 1'b0, 1'b0, 1'b1, 26'h0000BBB, NOP,         1'b1, 1'b0, 1'b0, 8);
    // Flush drops offer, vcnt keeps counting; flush+hold freezes outputs
    step(1'b1, 26'h2000004, 1'b0, 1'b0, 1'b1, NOP,         26'h2000004, 1'b0, 1'b1, 1'b1, 8);
    step(1'b1, 26'h0000CCC, 1'b1, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 8);
    step(1'b1, 26'h0000DDD, 1'b1, 1'b1, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 8);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 8);
    // Flush in FENCE_WAIT returns to RUN
    step(1'b1, 26'h2000005, 1'b0, 1'b0, 1'b1, NOP,         26'h2000005, 1'b0, 1'b1, 1'b1, 8);
    step(1'b1, FEN,         1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 9);
    step(1'b1, FEN,         1'b1, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 9);
    step(1'b1, 26'h0000EEE, 1'b0, 1'b0, 1'b1, 26'h0000EEE, NOP,         1'b1, 1'b0, 1'b0, 9);
    // Reset mid-run with vcnt=2
    step(1'b1, 26'h2000006, 1'b0, 1'b0, 1'b1, NOP,         26'h2000006, 1'b0, 1'b1, 1'b1, 9);
    step(1'b1, FEN,         1'b0, 1'b0, 1'b0, NOP,         NOP,         1'b0, 1'b0, 1'b1, 10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state(step_id);
    @(negedge clk);
    rst_n = 1'b1;
    // FENCE_WAIT and vcnt were discarded: fence accepted at once
    step(1'b1, FEN,         1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 26'h0000123, 1'b0, 1'b0, 1'b1, 26'h0000123, NOP,         1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, NOP,         NOP,         1'b0, 1'b0, 1'b0, 0);

    @(posedge clk);
    #3;
    chk("sb_drained", step_id, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
